// File: rtl/imem_arbiter.sv
// Two-port round-robin arbiter in front of a combinational instruction memory,
// with one response register per port. Optional counters: IMEM_ARB_PERF_EN.
module imem_arbiter #(
  parameter int          MEM_AW = 12,
  parameter logic [31:0] RST_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_req_addr,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_data,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_req_addr,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_data,
  output logic        p1_rsp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] perf_p0_grants,
  output logic [31:0] perf_p1_grants,
  output logic [31:0] perf_conflicts
);
  localparam int NP = 2;

  logic [NP-1:0]        req_valid, rsp_ready, elig, grant;
  logic [NP-1:0][31:0]  req_addr;
  logic [NP-1:0]        slot_valid, slot_err;
  logic [NP-1:0][31:0]  slot_data;
  logic                 last;
  logic                 addr_err;
  logic [31:0]          load_data;

  assign req_valid = {p1_req_valid, p0_req_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
  assign req_addr  = {p1_req_addr, p0_req_addr};

  // A slot draining this cycle can take a new request; nothing is granted in reset.
  assign elig = req_valid & (~slot_valid | rsp_ready) & {NP{rst_n}};

  always_comb begin
    grant = elig;
    if (&elig) grant = last ? 2'b01 : 2'b10;
  end

  assign p0_req_ready = grant[0];
  assign p1_req_ready = grant[1];

  always_comb begin
    mem_addr = RST_PC;
    if (grant[0]) mem_addr = req_addr[0];
    if (grant[1]) mem_addr = req_addr[1];
  end

  assign addr_err  = (mem_addr[1:0] != 2'b00) || ((mem_addr >> (MEM_AW + 2)) != 32'd0);
  assign load_data = addr_err ? 32'd0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (|grant) last <= grant[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_err   <= '0;
      slot_data  <= '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (grant[i]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= load_data;
          slot_err[i]   <= addr_err;
        end else if (rsp_ready[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign p0_rsp_valid = slot_valid[0];
  assign p0_rsp_data  = slot_data[0];
  assign p0_rsp_err   = slot_err[0];
  assign p1_rsp_valid = slot_valid[1];
  assign p1_rsp_data  = slot_data[1];
  assign p1_rsp_err   = slot_err[1];

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] cnt_g0, cnt_g1, cnt_cf;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_g0 <= '0;
      cnt_g1 <= '0;
      cnt_cf <= '0;
    end else begin
      if (grant[0] && cnt_g0 != '1) cnt_g0 <= cnt_g0 + 32'd1;
      if (grant[1] && cnt_g1 != '1) cnt_g1 <= cnt_g1 + 32'd1;
      if ((&elig) && cnt_cf != '1)  cnt_cf <= cnt_cf + 32'd1;
    end
  end

  assign perf_p0_grants = cnt_g0;
  assign perf_p1_grants = cnt_g1;
  assign perf_conflicts = cnt_cf;
`else
  assign perf_p0_grants = 32'd0;
  assign perf_p1_grants = 32'd0;
  assign perf_conflicts = 32'd0;
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational instruction memory between two requesters.
  - Port 0: instruction fetch.
  - Port 1: debug/loader read port.
- Each port uses a valid/ready request and response handshake.
- Response arrives 1 cycle after acceptance, from a per-port single-entry response register.
- Sits between the core front end / debug module and the instruction ROM; it is the only master of the memory address bus.

Parameters:
- MEM_AW, 12, word-address width of the memory. Legal byte range is 0 .. 2^(MEM_AW+2)-1.
- RST_PC, 32'h0000_0000, value of mem_addr while idle and in reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req_valid  in  1  port 0 request valid.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_addr  in  32  port 0 byte address.
- p0_rsp_valid  out  1  port 0 response valid.
- p0_rsp_ready  in  1  port 0 consumes response.
- p0_rsp_data  out  32  port 0 read word.
- p0_rsp_err  out  1  port 0 address error.
- p1_req_valid, p1_req_ready, p1_req_addr, p1_rsp_valid, p1_rsp_ready, p1_rsp_data, p1_rsp_err: same as port 0, for port 1.
- mem_addr  out  32  byte address to instruction memory.
- mem_rdata  in  32  combinational read data from memory.
- perf_p0_grants  out  32  see Optional Feature.
- perf_p1_grants  out  32  see Optional Feature.
- perf_conflicts  out  32  see Optional Feature.

Behaviour:
- Reset (rst_n low, async):
  - All rsp_valid = 0; all rsp_data = 0; all rsp_err = 0.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - req_ready forced 0 while rst_n low; mem_addr = RST_PC.
  - Reset mid-transaction discards any pending response; no response is replayed after reset.
- Eligibility:
  - Port i is eligible when req_valid_i && (!rsp_valid_i || rsp_ready_i).
  - A full slot that drains this cycle may accept a new request in the same cycle.
- Arbitration (combinational):
  - One eligible port: that port is granted.
  - Both eligible: grant the port != last.
  - last updates to the granted index on each accepted request; otherwise it holds.
- req_ready_i = grant_i.
  - May depend combinationally on req_valid_i.
  - Requesters must not make req_valid depend on req_ready.
- mem_addr = granted req_addr; RST_PC when no grant.
- Address check on the granted request:
  - err = (addr[1:0] != 0) || (addr[31:MEM_AW+2] != 0).
- On the accepting edge, the granted port's slot loads:
  - rsp_valid = 1.
  - rsp_data = err ? 0 : mem_rdata.
  - rsp_err = err.
- Latency: response valid exactly 1 cycle after acceptance.
- Throughput: 1 accepted request per cycle total, 1 per port per cycle.
- Slot not refilled this cycle: rsp_valid clears when rsp_ready is high, otherwise it holds. rsp_data and rsp_err hold until the slot is refilled.
- Backpressure: while port i's slot is full and rsp_ready_i is low, port i is ineligible. The other port may take every cycle.
- Error requests consume a grant and a response slot exactly like good reads.
- Request ordering within a port is preserved. There is no ordering between ports.
- Starvation: if both ports are continuously eligible, each is granted every 2 cycles.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined:
  - perf_p0_grants increments on each port 0 acceptance.
  - perf_p1_grants increments on each port 1 acceptance.
  - perf_conflicts increments in each cycle where both ports are eligible.
  - All three are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Not defined: the three perf outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Port 0 only, addresses 0x0, 0x4, 0x8 back-to-back, rsp_ready=1 -> three responses on consecutive cycles, each 1 cycle after acceptance, data = mem words 0, 1, 2, err=0.
- Both ports valid every cycle (p0 addr 0x10, p1 addr 0x20), rsp_ready=1 -> first grant to p0, then strict alternation; after 10 cycles perf_p0_grants=5, perf_p1_grants=5, perf_conflicts=10 (with IMEM_ARB_PERF_EN).
- Port 1 addr 0x2 (misaligned), then addr 0x4000 with MEM_AW=12 -> two responses with err=1, data=0; next request to 0x4 returns mem word 1, err=0.
- Port 0 rsp_ready=0 with a full slot, port 0 and port 1 both valid -> p0_req_ready=0 and port 1 granted every cycle. Raising p0_rsp_ready for one cycle drains port 0's slot and lets it accept a new request in that same cycle.
- rst_n dropped asynchronously mid-cycle with both slots full -> rsp_valid=0 immediately, mem_addr=RST_PC. After release, the first tie goes to port 0 and no stale response appears.
